// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: word-organised RV32I data memory behind a valid/ready
// request port. Handles LB/LH/LW/LBU/LHU/SB/SH/SW with programmable access
// latency, byte-enable writes and optional splitting of word-crossing
// accesses into two back-to-back word accesses.
module data_memory_ctrl #(
   parameter int unsigned DEPTH            = 1024,
   parameter int unsigned LATENCY          = 1,
   parameter bit          ALLOW_MISALIGNED = 1'b1,
   parameter string       INIT_FILE        = ""
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [2:0]  funct3,
   input  logic [31:0] endereco,
   input  logic [31:0] write_data,
   output logic        resp_valid,
   output logic [31:0] read_data,
   output logic        erro
);

   localparam int unsigned WORDS = DEPTH / 4;
   localparam int unsigned AW    = (WORDS > 1) ? $clog2(WORDS) : 1;
   localparam int unsigned BW    = AW + 2;   // byte-address bits that index the array

   typedef enum logic [1:0] {S_IDLE, S_BUSY, S_SECOND, S_RESP} state_e;

   logic [31:0]   mem_q [WORDS];

   state_e        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic          load_q, load_d;
   logic [2:0]    f3_q, f3_d;
   logic [BW-1:0] addr_q, addr_d;
   logic [31:0]   wdata_q, wdata_d;
   logic          err_q, err_d;
   logic [31:0]   hold_q, hold_d;
   logic [31:0]   read_data_q, read_data_d;
   logic          erro_q, erro_d;

   // Access size in bytes from the low two funct3 bits (B/BU=1, H/HU=2, W=4).
   function automatic logic [2:0] size_of(input logic [1:0] sz);
      case (sz)
         2'b00:   return 3'd1;
         2'b01:   return 3'd2;
         default: return 3'd4;
      endcase
   endfunction

   // Sign- or zero-extend the little-endian load bytes sitting in raw[15:0].
   function automatic logic [31:0] extend(input logic [2:0] f3, input logic [31:0] raw);
      case (f3)
         3'b000:  return {{24{raw[7]}}, raw[7:0]};
         3'b001:  return {{16{raw[15]}}, raw[15:0]};
         3'b100:  return {24'd0, raw[7:0]};
         3'b101:  return {16'd0, raw[15:0]};
         default: return raw;
      endcase
   endfunction

   // Request legality, judged on the live request fields at accept time.
   logic [2:0]  acc_size;
   logic [32:0] acc_last;
   logic        acc_bad_f3, acc_bad_range, acc_misaligned, acc_err;

   // Classify the incoming request: illegal encoding, out of range, misaligned.
   always_comb begin
      acc_size       = size_of(funct3[1:0]);
      acc_bad_f3     = (funct3 == 3'b011) || (funct3[2:1] == 2'b11) || (funct3[2] && mem_write);
      acc_last       = {1'b0, endereco} + {30'd0, acc_size} - 33'd1;
      acc_bad_range  = acc_last >= 33'(DEPTH);
      acc_misaligned = ((acc_size == 3'd2) && endereco[0]) ||
                       ((acc_size == 3'd4) && (endereco[1:0] != 2'b00));
      acc_err        = acc_bad_f3 || acc_bad_range || (acc_misaligned && !ALLOW_MISALIGNED);
   end

   // Lane view of the captured request: a 64-bit window over word and word+1.
   logic [1:0]    off;
   logic [2:0]    cur_size;
   logic [4:0]    shamt;
   logic          crosses;
   logic [AW-1:0] widx, widx_next;
   logic [7:0]    be8;
   logic [63:0]   wd64;
   logic [31:0]   word_a, word_b, merged;

   // Place store bytes/enables across the two-word window and align load bytes.
   always_comb begin
      off       = addr_q[1:0];
      cur_size  = size_of(f3_q[1:0]);
      shamt     = {off, 3'b000};
      crosses   = ({1'b0, off} + cur_size) > 3'd4;
      widx      = addr_q[BW-1:2];
      widx_next = widx + AW'(1);
      be8       = {4'b0000, (cur_size == 3'd4) ? 4'hF : (cur_size == 3'd2) ? 4'h3 : 4'h1} << off;
      wd64      = {32'd0, wdata_q} << shamt;
      word_a    = mem_q[widx];
      word_b    = mem_q[widx_next];
      merged    = 32'({word_b, hold_q} >> shamt);
   end

   // Memory write port, driven by the FSM below.
   logic          mem_we;
   logic [AW-1:0] mem_widx;
   logic [3:0]    mem_be;
   logic [31:0]   mem_wdata;

   // Next-state, capture and memory-port control for IDLE/BUSY/SECOND/RESP.
   // NOTE: every signal gets a default before the case so no path leaves one
   // unassigned; a missing default here would infer a latch.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      load_d      = load_q;
      f3_d        = f3_q;
      addr_d      = addr_q;
      wdata_d     = wdata_q;
      err_d       = err_q;
      hold_d      = hold_q;
      read_data_d = read_data_q;
      erro_d      = erro_q;
      mem_we      = 1'b0;
      mem_widx    = widx;
      mem_be      = be8[3:0];
      mem_wdata   = wd64[31:0];

      unique case (state_q)
         S_IDLE: begin
            // A request with mem_read == mem_write is swallowed without a response.
            if (req_valid && req_ready && (mem_read != mem_write)) begin
               load_d  = mem_read;
               f3_d    = funct3;
               addr_d  = endereco[BW-1:0];
               wdata_d = write_data;
               err_d   = acc_err;
               cnt_d   = 3'(LATENCY - 1);
               state_d = S_BUSY;
            end
         end
         S_BUSY: begin
            if (cnt_q != 3'd0) begin
               cnt_d = cnt_q - 3'd1;
            end else if (err_q) begin
               read_data_d = '0;
               erro_d      = 1'b1;
               state_d     = S_RESP;
            end else begin
               mem_we = !load_q;
               if (crosses) begin
                  hold_d  = word_a;
                  state_d = S_SECOND;
               end else begin
                  read_data_d = load_q ? extend(f3_q, word_a >> shamt) : '0;
                  erro_d      = 1'b0;
                  state_d     = S_RESP;
               end
            end
         end
         S_SECOND: begin
            mem_we      = !load_q;
            mem_widx    = widx_next;
            mem_be      = be8[7:4];
            mem_wdata   = wd64[63:32];
            read_data_d = load_q ? extend(f3_q, merged) : '0;
            erro_d      = 1'b0;
            state_d     = S_RESP;
         end
         S_RESP:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Control and response registers with synchronous reset.
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its _d, independent of statement order.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         load_q      <= 1'b0;
         f3_q        <= '0;
         addr_q      <= '0;
         wdata_q     <= '0;
         err_q       <= 1'b0;
         hold_q      <= '0;
         read_data_q <= '0;
         erro_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         load_q      <= load_d;
         f3_q        <= f3_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         err_q       <= err_d;
         hold_q      <= hold_d;
         read_data_q <= read_data_d;
         erro_q      <= erro_d;
      end
   end

   // Byte-enable word write; a reset edge suppresses any write in flight.
   // NOTE: the storage array has no reset branch, so contents survive reset and
   // the array can map onto RAM macros.
   always_ff @(posedge clk) begin
      if (mem_we && !reset) begin
         for (int b = 0; b < 4; b++) begin
            if (mem_be[b]) mem_q[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
         end
      end
   end

   // Power-up contents: all zero.
   initial begin
      for (int w = 0; w < int'(WORDS); w++) mem_q[w] = '0;
   end

   assign req_ready  = (state_q == S_IDLE) && !reset;
   assign resp_valid = (state_q == S_RESP);
   assign read_data  = read_data_q;
   assign erro       = erro_q;

endmodule

// File: tb/tb_data_memory_ctrl.sv
// Bench for data_memory_ctrl: two instances (LATENCY=3 with splitting, and
// LATENCY=1 with misaligned trapping) driven by directed and random requests,
// compared against a byte-array reference model.
module tb_data_memory_ctrl;

   localparam int N     = 2;
   localparam int DEP_A = 256;
   localparam int LAT_A = 3;
   localparam int DEP_B = 64;
   localparam int LAT_B = 1;

   int dep   [N] = '{DEP_A, DEP_B};
   int lat   [N] = '{LAT_A, LAT_B};
   bit allow [N] = '{1'b1, 1'b0};

   logic        clk = 1'b0;
   logic        reset      [N];
   logic        req_valid  [N];
   logic        req_ready  [N];
   logic        mem_read   [N];
   logic        mem_write  [N];
   logic [2:0]  funct3     [N];
   logic [31:0] endereco   [N];
   logic [31:0] write_data [N];
   logic        resp_valid [N];
   logic [31:0] read_data  [N];
   logic        erro       [N];

   logic [7:0]  model [N][256];

   int total_cnt = 0;
   int pass_cnt  = 0;
   int fail_cnt  = 0;

   always #5 clk = ~clk;

   data_memory_ctrl #(.DEPTH(DEP_A), .LATENCY(LAT_A), .ALLOW_MISALIGNED(1'b1), .INIT_FILE("")) dut_a (
      .clk(clk), .reset(reset[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .mem_read(mem_read[0]), .mem_write(mem_write[0]), .funct3(funct3[0]),
      .endereco(endereco[0]), .write_data(write_data[0]), .resp_valid(resp_valid[0]),
      .read_data(read_data[0]), .erro(erro[0]));

   data_memory_ctrl #(.DEPTH(DEP_B), .LATENCY(LAT_B), .ALLOW_MISALIGNED(1'b0), .INIT_FILE("")) dut_b (
      .clk(clk), .reset(reset[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .mem_read(mem_read[1]), .mem_write(mem_write[1]), .funct3(funct3[1]),
      .endereco(endereco[1]), .write_data(write_data[1]), .resp_valid(resp_valid[1]),
      .read_data(read_data[1]), .erro(erro[1]));

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
      total_cnt++;
      assert (obs === want) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Reference: byte-addressed memory, legality from the RV32I size/sign rules.
   function automatic void model_access(input int i, input bit rd, input logic [2:0] f3,
         input logic [31:0] addr, input logic [31:0] wd,
         output logic [31:0] rdata, output bit err, output int lat_exp, output bit lat_known);
      int size;
      bit legal;
      int off;
      longint unsigned end_addr;
      logic [31:0] v;
      legal = 1'b1;
      size  = 1;
      case (f3)
         3'b000, 3'b100: size = 1;
         3'b001, 3'b101: size = 2;
         3'b010:         size = 4;
         default:        legal = 1'b0;
      endcase
      if (!rd && f3[2]) legal = 1'b0;
      end_addr  = longint'(addr) + longint'(size) - 1;
      off       = int'(addr % 4);
      err       = !legal || (end_addr >= longint'(dep[i])) || (!allow[i] && (addr % size != 0));
      rdata     = '0;
      lat_exp   = lat[i] + 1 + ((!err && off + size > 4) ? 1 : 0);
      lat_known = legal && !(err && off + size > 4);
      if (err) return;
      if (rd) begin
         v = '0;
         for (int k = 0; k < size; k++) v = v | (32'(model[i][addr + k]) << (8 * k));
         if (f3 == 3'b000 && v[7])  v = v + 32'hFFFF_FF00;
         if (f3 == 3'b001 && v[15]) v = v + 32'hFFFF_0000;
         rdata = v;
      end else begin
         for (int k = 0; k < size; k++) model[i][addr + k] = wd[8*k +: 8];
      end
   endfunction

   task automatic start_req(input int i, input bit rd, input bit wr, input logic [2:0] f3,
         input logic [31:0] addr, input logic [31:0] wd, input string tag);
      int k = 0;
      while (req_ready[i] !== 1'b1 && k < 50) begin tick(); k++; end
      check({tag, " ready"}, {31'd0, req_ready[i]}, 32'd1);
      req_valid[i]  = 1'b1;
      mem_read[i]   = rd;
      mem_write[i]  = wr;
      funct3[i]     = f3;
      endereco[i]   = addr;
      write_data[i] = wd;
      tick();
      req_valid[i]  = 1'b0;
      endereco[i]   = $urandom();
      write_data[i] = $urandom();
   endtask

   task automatic do_req(input int i, input bit rd, input bit wr, input logic [2:0] f3,
         input logic [31:0] addr, input logic [31:0] wd, input string tag);
      logic [31:0] want_d;
      bit want_e, lat_known, got, ready_low;
      int lat_exp, k;
      start_req(i, rd, wr, f3, addr, wd, tag);
      if (rd == wr) begin
         got = 1'b0;
         for (int c = 0; c < lat[i] + 4; c++) begin
            if (resp_valid[i] === 1'b1) got = 1'b1;
            tick();
         end
         check({tag, " noop resp"}, {31'd0, got}, 32'd0);
         check({tag, " noop ready"}, {31'd0, req_ready[i]}, 32'd1);
         return;
      end
      model_access(i, rd, f3, addr, wd, want_d, want_e, lat_exp, lat_known);
      k = 1; got = 1'b0; ready_low = 1'b1;
      while (k <= 20) begin
         if (req_ready[i] !== 1'b0) ready_low = 1'b0;
         if (resp_valid[i] === 1'b1) begin got = 1'b1; break; end
         tick();
         k++;
      end
      check({tag, " resp seen"}, {31'd0, got}, 32'd1);
      if (!got) return;
      if (lat_known) check({tag, " latency"}, 32'(k), 32'(lat_exp));
      check({tag, " ready low"}, {31'd0, ready_low}, 32'd1);
      check({tag, " erro"}, {31'd0, erro[i]}, {31'd0, want_e});
      check({tag, " data"}, read_data[i], want_d);
      tick();
      check({tag, " pulse"}, {31'd0, resp_valid[i]}, 32'd0);
      check({tag, " hold"}, read_data[i], want_d);
      check({tag, " ready back"}, {31'd0, req_ready[i]}, 32'd1);
   endtask

   task automatic random_ops(input int i, input int n);
      for (int t = 0; t < n; t++) begin
         logic [2:0] f3;
         logic [31:0] addr;
         bit rd, wr;
         int r;
         r = $urandom_range(0, 15);
         if (r < 13) begin
            case ($urandom_range(0, 4))
               0: f3 = 3'b000;
               1: f3 = 3'b001;
               2: f3 = 3'b010;
               3: f3 = 3'b100;
               default: f3 = 3'b101;
            endcase
         end else begin
            f3 = 3'($urandom_range(0, 7));
         end
         r = $urandom_range(0, 9);
         if (r == 0) begin
            rd = 1'($urandom_range(0, 1));
            wr = rd;
         end else begin
            rd = (r < 5);
            wr = !rd;
         end
         if ($urandom_range(0, 7) == 0) addr = 32'(dep[i] - 6 + int'($urandom_range(0, 7)));
         else addr = 32'($urandom_range(0, 31));
         do_req(i, rd, wr, f3, addr, $urandom(), $sformatf("rand%0d.%0d", i, t));
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit got;
      for (int i = 0; i < N; i++) begin
         for (int a = 0; a < 256; a++) model[i][a] = 8'h00;
         reset[i] = 1'b1; req_valid[i] = 1'b0; mem_read[i] = 1'b0; mem_write[i] = 1'b0;
         funct3[i] = 3'b000; endereco[i] = '0; write_data[i] = '0;
      end

      // Reset state.
      tick(); tick();
      check("reset ready low", {31'd0, req_ready[0]}, 32'd0);
      reset[0] = 1'b0; reset[1] = 1'b0;
      #1;
      for (int i = 0; i < N; i++) begin
         check($sformatf("reset%0d ready", i), {31'd0, req_ready[i]}, 32'd1);
         check($sformatf("reset%0d resp", i), {31'd0, resp_valid[i]}, 32'd0);
         check($sformatf("reset%0d data", i), read_data[i], 32'd0);
         check($sformatf("reset%0d erro", i), {31'd0, erro[i]}, 32'd0);
      end

      // T1 / T2: sizes and sign handling, timing at LATENCY=3.
      do_req(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF, "t1 sw");
      do_req(0, 1, 0, 3'b010, 32'h10, 32'h0, "t1 lw");
      do_req(0, 1, 0, 3'b000, 32'h13, 32'h0, "t1 lb");
      do_req(0, 1, 0, 3'b100, 32'h13, 32'h0, "t1 lbu");
      do_req(0, 1, 0, 3'b001, 32'h12, 32'h0, "t1 lh");
      do_req(0, 1, 0, 3'b101, 32'h10, 32'h0, "t1 lhu");

      // T3: split store and load, half at offset 1 and 3.
      do_req(0, 0, 1, 3'b010, 32'h0C, 32'h5A5A5A5A, "t3 pre");
      do_req(0, 0, 1, 3'b010, 32'h0E, 32'h11223344, "t3 sw split");
      do_req(0, 1, 0, 3'b010, 32'h0C, 32'h0, "t3 lw 0c");
      do_req(0, 1, 0, 3'b010, 32'h10, 32'h0, "t3 lw 10");
      do_req(0, 1, 0, 3'b010, 32'h0E, 32'h0, "t3 lw split");
      do_req(0, 1, 0, 3'b001, 32'h11, 32'h0, "t3 lh off1");
      do_req(0, 1, 0, 3'b101, 32'h0F, 32'h0, "t3 lhu off3");

      // T4: trapping instance.
      do_req(1, 0, 1, 3'b010, 32'h00, 32'h55667788, "t4 pre0");
      do_req(1, 0, 1, 3'b010, 32'h04, 32'h99AABBCC, "t4 pre4");
      do_req(1, 1, 0, 3'b001, 32'h01, 32'h0, "t4 lh mis");
      do_req(1, 0, 1, 3'b001, 32'h03, 32'h0000FFFF, "t4 sh mis");
      do_req(1, 1, 0, 3'b010, 32'h00, 32'h0, "t4 lw 0");
      do_req(1, 1, 0, 3'b010, 32'h04, 32'h0, "t4 lw 4");

      // T5: range, encoding and no-op requests.
      do_req(0, 0, 1, 3'b000, 32'(DEP_A), 32'hFF, "t5 sb depth");
      do_req(0, 1, 0, 3'b010, 32'(DEP_A - 2), 32'h0, "t5 lw depth-2");
      do_req(0, 1, 0, 3'b010, 32'(DEP_A - 4), 32'h0, "t5 lw depth-4");
      do_req(0, 1, 0, 3'b011, 32'h10, 32'h0, "t5 f3 011");
      do_req(0, 0, 1, 3'b100, 32'h10, 32'h0, "t5 sbu");
      do_req(0, 1, 1, 3'b010, 32'h10, 32'h0, "t5 rw noop");
      do_req(0, 0, 0, 3'b010, 32'h10, 32'h0, "t5 idle noop");

      // T6: reset during BUSY aborts the store with no response.
      do_req(0, 0, 1, 3'b010, 32'h20, 32'h01234567, "t6 pre");
      start_req(0, 0, 1, 3'b010, 32'h20, 32'hAAAAAAAA, "t6 sw");
      reset[0] = 1'b1;
      #1;
      check("t6 ready in reset", {31'd0, req_ready[0]}, 32'd0);
      tick();
      reset[0] = 1'b0;
      #1;
      check("t6 ready after reset", {31'd0, req_ready[0]}, 32'd1);
      got = 1'b0;
      for (int c = 0; c < 6; c++) begin
         if (resp_valid[0] === 1'b1) got = 1'b1;
         tick();
      end
      check("t6 no resp", {31'd0, got}, 32'd0);
      do_req(0, 1, 0, 3'b010, 32'h20, 32'h0, "t6 lw");

      // Reset while a split store is in SECOND keeps only the phase-1 bytes.
      do_req(0, 0, 1, 3'b010, 32'h2C, 32'h76543210, "t6b pre2c");
      do_req(0, 0, 1, 3'b010, 32'h30, 32'hFEDCBA98, "t6b pre30");
      start_req(0, 0, 1, 3'b010, 32'h2E, 32'hCAFEF00D, "t6b sw");
      tick(); tick(); tick();
      reset[0] = 1'b1;
      tick();
      reset[0] = 1'b0;
      #1;
      model[0][8'h2E] = 8'h0D;
      model[0][8'h2F] = 8'hF0;
      do_req(0, 1, 0, 3'b010, 32'h2C, 32'h0, "t6b lw 2c");
      do_req(0, 1, 0, 3'b010, 32'h30, 32'h0, "t6b lw 30");

      // Randomised traffic on both configurations.
      random_ops(0, 60);
      random_ops(1, 60);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
